// File: rtl/alu16_pkg.sv
// Shared constants for the 16-bit ALU datapath: widths, flag positions, op codes.
package alu16_pkg;

   localparam int unsigned DATA_W   = 16;
   localparam int unsigned NUM_REGS = 8;
   localparam int unsigned AW       = 3;

   // Bit positions of the status flags inside the {N,Z,C} flag word
   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_Z = 1;
   localparam int unsigned FLAG_C = 0;

   typedef enum logic [2:0] {
      OP_ADD = 3'd0,
      OP_SUB = 3'd1,
      OP_AND = 3'd2,
      OP_OR  = 3'd3,
      OP_XOR = 3'd4,
      OP_SHL = 3'd5,
      OP_SHR = 3'd6,
      OP_MOV = 3'd7
   } alu_op_t;

endpackage

// File: rtl/reg_array8x16.sv
// Register storage: one synchronous write port, two combinational read ports,
// register 0 hardwired to zero (no storage behind it).
module reg_array8x16 #(
   parameter int unsigned DATA_W   = alu16_pkg::DATA_W,
   parameter int unsigned NUM_REGS = alu16_pkg::NUM_REGS,
   parameter int unsigned AW       = alu16_pkg::AW
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [AW-1:0]     raddr_a,
   output logic [DATA_W-1:0] rdata_a,
   input  logic [AW-1:0]     raddr_b,
   output logic [DATA_W-1:0] rdata_b
);

   import alu16_pkg::*;

   logic [DATA_W-1:0] mem [1:NUM_REGS-1];

   // Storage update; address 0 matches no entry so its writes vanish
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 1; i < int'(NUM_REGS); i++) mem[i] <= '0;
      end else begin
         for (int i = 1; i < int'(NUM_REGS); i++) begin
            if (we && (waddr == AW'(i))) mem[i] <= wdata;
         end
      end
   end

   // Read port A; address 0 or unpopulated addresses return zero
   always_comb begin
      rdata_a = '0;
      for (int i = 1; i < int'(NUM_REGS); i++) begin
         if (raddr_a == AW'(i)) rdata_a = mem[i];
      end
   end

   // Read port B; same decoding as port A
   always_comb begin
      rdata_b = '0;
      for (int i = 1; i < int'(NUM_REGS); i++) begin
         if (raddr_b == AW'(i)) rdata_b = mem[i];
      end
   end

endmodule

// File: rtl/reg_file_wb.sv
// Write-back stage: one-entry pipeline register in front of the register file,
// valid/ready handshake with stall, and operand forwarding from the pending result.
module reg_file_wb #(
   parameter int unsigned DATA_W   = alu16_pkg::DATA_W,
   parameter int unsigned NUM_REGS = alu16_pkg::NUM_REGS,
   parameter int unsigned AW       = alu16_pkg::AW
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] Y,
   input  logic              N,
   input  logic              Z,
   input  logic              C,
   input  logic [AW-1:0]     w_addr,
   input  logic              w_en,
   input  logic              flag_en,
   input  logic              stall,
   input  logic [AW-1:0]     r_addr,
   input  logic [AW-1:0]     s_addr,
   output logic [DATA_W-1:0] R,
   output logic [DATA_W-1:0] S,
   output logic [2:0]        flags,
   output logic              busy
);

   import alu16_pkg::*;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] data;
      logic [AW-1:0]     addr;
      logic              we;
      logic              fe;
      logic              n;
      logic              z;
      logic              c;
   } pipe_t;

   pipe_t             p;
   logic              transfer;
   logic              commit;
   logic              rf_we;
   logic [DATA_W-1:0] rf_r;
   logic [DATA_W-1:0] rf_s;

   // Handshake: accept unless a pending result is held by stall
   always_comb begin
      in_ready = !(p.valid && stall);
      transfer = in_valid && in_ready;
      commit   = p.valid && !stall;
      rf_we    = commit && p.we;
   end

   // Pipeline register: reload on transfer (covers commit+transfer), clear on bare commit
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p <= '0;
      end else if (transfer) begin
         p.valid <= 1'b1;
         p.data  <= Y;
         p.addr  <= w_addr;
         p.we    <= w_en;
         p.fe    <= flag_en;
         p.n     <= N;
         p.z     <= Z;
         p.c     <= C;
      end else if (commit) begin
         p.valid <= 1'b0;
      end
   end

   // Committed status flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags <= '0;
      end else if (commit && p.fe) begin
         flags[FLAG_N] <= p.n;
         flags[FLAG_Z] <= p.z;
         flags[FLAG_C] <= p.c;
      end
   end

   reg_array8x16 #(
      .DATA_W   (DATA_W),
      .NUM_REGS (NUM_REGS),
      .AW       (AW)
   ) u_regs (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (rf_we),
      .waddr   (p.addr),
      .wdata   (p.data),
      .raddr_a (r_addr),
      .rdata_a (rf_r),
      .raddr_b (s_addr),
      .rdata_b (rf_s)
   );

   // Operand forwarding from the pending result; register 0 never forwards
   always_comb begin
      R = rf_r;
      S = rf_s;
      if (p.valid && p.we && (p.addr == r_addr) && (r_addr != '0)) R = p.data;
      if (p.valid && p.we && (p.addr == s_addr) && (s_addr != '0)) S = p.data;
   end

   assign busy = p.valid;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: per-cycle vector table plus a reset-under-stall sequence.
module tb_reg_file_wb;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] Y;
   logic        N, Z, C;
   logic [2:0]  w_addr;
   logic        w_en;
   logic        flag_en;
   logic        stall;
   logic [2:0]  r_addr, s_addr;
   logic [15:0] R, S;
   logic [2:0]  flags;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;

   reg_file_wb dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .Y        (Y),
      .N        (N),
      .Z        (Z),
      .C        (C),
      .w_addr   (w_addr),
      .w_en     (w_en),
      .flag_en  (flag_en),
      .stall    (stall),
      .r_addr   (r_addr),
      .s_addr   (s_addr),
      .R        (R),
      .S        (S),
      .flags    (flags),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [15:0] y;
      logic [2:0]  nzc;
      logic [2:0]  wa;
      logic        we;
      logic        fe;
      logic        st;
      logic [2:0]  ra;
      logic [2:0]  sa;
      logic        rdy;
      logic [15:0] r;
      logic [15:0] s;
      logic [2:0]  fl;
      logic        bsy;
   } vec_t;

   vec_t vecs [24];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic rdy, input logic [15:0] r,
                            input logic [15:0] s, input logic [2:0] fl, input logic bsy);
      chk({tag, ".in_ready"}, 16'(in_ready), 16'(rdy));
      chk({tag, ".R"},        R,             r);
      chk({tag, ".S"},        S,             s);
      chk({tag, ".flags"},    16'(flags),    16'(fl));
      chk({tag, ".busy"},     16'(busy),     16'(bsy));
   endtask

   task automatic drive(input logic v, input logic [15:0] y, input logic [2:0] nzc,
                        input logic [2:0] wa, input logic we, input logic fe,
                        input logic st, input logic [2:0] ra, input logic [2:0] sa);
      in_valid = v;   Y = y;
      N = nzc[2];     Z = nzc[1];   C = nzc[0];
      w_addr = wa;    w_en = we;    flag_en = fe;
      stall = st;     r_addr = ra;  s_addr = sa;
   endtask

   initial begin
      //           v  y         nzc     wa we fe st ra sa  rdy r         s         fl      bsy
      // single write to r3, forwarded then committed
      vecs[0]  = '{1, 16'h1234, 3'b000, 3, 1, 0, 0, 3, 0,  1, 16'h0000, 16'h0000, 3'b000, 0};
      vecs[1]  = '{0, 16'h0000, 3'b000, 0, 0, 0, 0, 3, 0,  1, 16'h1234, 16'h0000, 3'b000, 1};
      vecs[2]  = '{0, 16'h0000, 3'b000, 0, 0, 0, 0, 3, 0,  1, 16'h1234, 16'h0000, 3'b000, 0};
      // r5 <= AAAA held by stall for 4 cycles; a stalled offer must be refused
      vecs[3]  = '{1, 16'hAAAA, 3'b000, 5, 1, 0, 1, 3, 5,  1, 16'h1234, 16'h0000, 3'b000, 0};
      vecs[4]  = '{0, 16'h0000, 3'b000, 0, 0, 0, 1, 5, 5,  0, 16'hAAAA, 16'hAAAA, 3'b000, 1};
      vecs[5]  = '{1, 16'hBBBB, 3'b111, 5, 1, 1, 1, 5, 5,  0, 16'hAAAA, 16'hAAAA, 3'b000, 1};
      vecs[6]  = '{0, 16'h0000, 3'b000, 0, 0, 0, 1, 5, 5,  0, 16'hAAAA, 16'hAAAA, 3'b000, 1};
      vecs[7]  = '{0, 16'h0000, 3'b000, 0, 0, 0, 1, 5, 5,  0, 16'hAAAA, 16'hAAAA, 3'b000, 1};
      vecs[8]  = '{0, 16'h0000, 3'b000, 0, 0, 0, 0, 5, 5,  1, 16'hAAAA, 16'hAAAA, 3'b000, 1};
      vecs[9]  = '{0, 16'h0000, 3'b000, 0, 0, 0, 0, 5, 5,  1, 16'hAAAA, 16'hAAAA, 3'b000, 0};
      // back-to-back writes 1,2,3 to r2
      vecs[10] = '{1, 16'h0001, 3'b000, 2, 1, 0, 0, 2, 5,  1, 16'h0000, 16'hAAAA, 3'b000, 0};
      vecs[11] = '{1, 16'h0002, 3'b000, 2, 1, 0, 0, 2, 5,  1, 16'h0001, 16'hAAAA, 3'b000, 1};
      vecs[12] = '{1, 16'h0003, 3'b000, 2, 1, 0, 0, 2, 5,  1, 16'h0002, 16'hAAAA, 3'b000, 1};
      vecs[13] = '{0, 16'h0000, 3'b000, 0, 0, 0, 0, 2, 5,  1, 16'h0003, 16'hAAAA, 3'b000, 1};
      vecs[14] = '{0, 16'h0000, 3'b000, 0, 0, 0, 0, 2, 5,  1, 16'h0003, 16'hAAAA, 3'b000, 0};
      // write to r0 is dropped, flags still commit as 101
      vecs[15] = '{1, 16'hFFFF, 3'b101, 0, 1, 1, 0, 0, 2,  1, 16'h0000, 16'h0003, 3'b000, 0};
      vecs[16] = '{0, 16'h0000, 3'b000, 0, 0, 0, 0, 0, 2,  1, 16'h0000, 16'h0003, 3'b000, 1};
      vecs[17] = '{0, 16'h0000, 3'b000, 0, 0, 0, 0, 0, 2,  1, 16'h0000, 16'h0003, 3'b101, 0};
      // result with no enables: occupies P, no forwarding, no effect
      vecs[18] = '{1, 16'h5555, 3'b010, 2, 0, 0, 0, 2, 2,  1, 16'h0003, 16'h0003, 3'b101, 0};
      vecs[19] = '{0, 16'h0000, 3'b000, 0, 0, 0, 0, 2, 2,  1, 16'h0003, 16'h0003, 3'b101, 1};
      vecs[20] = '{0, 16'h0000, 3'b000, 0, 0, 0, 0, 2, 2,  1, 16'h0003, 16'h0003, 3'b101, 0};
      // flag-only result: flags become 010, r4 untouched
      vecs[21] = '{1, 16'h7777, 3'b010, 4, 0, 1, 0, 4, 4,  1, 16'h0000, 16'h0000, 3'b101, 0};
      vecs[22] = '{0, 16'h0000, 3'b000, 0, 0, 0, 0, 4, 4,  1, 16'h0000, 16'h0000, 3'b101, 1};
      vecs[23] = '{0, 16'h0000, 3'b000, 0, 0, 0, 0, 4, 4,  1, 16'h0000, 16'h0000, 3'b010, 0};

      clk     = 1'b0;
      reset_n = 1'b0;
      drive(0, 16'h0, 3'b000, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;

      // reset state on every read address
      for (int i = 0; i < 8; i++) begin
         drive(0, 16'h0, 3'b000, 0, 0, 0, 0, 3'(i), 3'(i));
         #4;
         check_all($sformatf("rst%0d", i), 1'b1, 16'h0, 16'h0, 3'b000, 1'b0);
         @(posedge clk);
         #1;
      end

      // vector table: drive, check mid-cycle, advance one edge
      for (int i = 0; i < 24; i++) begin
         drive(vecs[i].v, vecs[i].y, vecs[i].nzc, vecs[i].wa, vecs[i].we, vecs[i].fe,
               vecs[i].st, vecs[i].ra, vecs[i].sa);
         #4;
         check_all($sformatf("v%0d", i), vecs[i].rdy, vecs[i].r, vecs[i].s,
                   vecs[i].fl, vecs[i].bsy);
         @(posedge clk);
         #1;
      end

      // reset asserted while a stalled result to r6 is pending
      drive(1, 16'h4321, 3'b000, 6, 1, 0, 1, 6, 3);
      @(posedge clk);
      #1;
      drive(0, 16'h0, 3'b000, 0, 0, 0, 1, 6, 3);
      #3;
      check_all("stl", 1'b0, 16'h4321, 16'h1234, 3'b010, 1'b1);
      reset_n = 1'b0;
      #1;
      check_all("rst_async", 1'b1, 16'h0000, 16'h0000, 3'b000, 1'b0);
      #2;
      reset_n = 1'b1;
      stall   = 1'b0;
      @(posedge clk);
      #1;
      #3;
      check_all("post_rst", 1'b1, 16'h0000, 16'h0000, 3'b000, 1'b0);

      // block works normally after reset
      drive(1, 16'h0BAD, 3'b000, 6, 1, 0, 0, 6, 5);
      @(posedge clk);
      #1;
      drive(0, 16'h0, 3'b000, 0, 0, 0, 0, 6, 5);
      #3;
      check_all("rearm_fwd", 1'b1, 16'h0BAD, 16'h0000, 3'b000, 1'b1);
      @(posedge clk);
      #4;
      check_all("rearm_rf", 1'b1, 16'h0BAD, 16'h0000, 3'b000, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
